// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Package : fc_pkg
// Shared widths and the state encoding for the fully connected layer sequencer.
// Rev     : 1.0
// ============================================================================
package fc_pkg;

  localparam int FC_DATA_W  = 8;
  localparam int FC_CNT_W   = 8;
  localparam int FC_WADDR_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/fc_layer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : fc_layer_ctrl_if
// Memory, MAC-core and result buses of the layer sequencer (master = sequencer).
// Rev       : 1.0
// ============================================================================
interface fc_layer_ctrl_if
  import fc_pkg::*;
#(
  parameter int DATA_W  = FC_DATA_W,
  parameter int CNT_W   = FC_CNT_W,
  parameter int WADDR_W = FC_WADDR_W
);

  logic                  o_mem_en;
  logic [CNT_W-1:0]      o_node_addr;
  logic [WADDR_W-1:0]    o_wegt_addr;
  logic                  o_bias_en;
  logic [CNT_W-1:0]      o_bias_addr;
  logic [DATA_W-1:0]     i_bias_data;
  logic                  o_core_run;
  logic                  o_core_valid;
  logic [DATA_W-1:0]     o_core_bias;
  logic [4*DATA_W-1:0]   i_core_result;
  logic                  o_res_valid;
  logic                  i_res_ready;
  logic [CNT_W-1:0]      o_res_addr;
  logic [4*DATA_W-1:0]   o_res_data;

  modport master (
    output o_mem_en, o_node_addr, o_wegt_addr,
    output o_bias_en, o_bias_addr,
    input  i_bias_data,
    output o_core_run, o_core_valid, o_core_bias,
    input  i_core_result,
    output o_res_valid, o_res_addr, o_res_data,
    input  i_res_ready
  );

  modport slave (
    input  o_mem_en, o_node_addr, o_wegt_addr,
    input  o_bias_en, o_bias_addr,
    output i_bias_data,
    input  o_core_run, o_core_valid, o_core_bias,
    output i_core_result,
    input  o_res_valid, o_res_addr, o_res_data,
    output i_res_ready
  );

endinterface
`default_nettype wire

// File: rtl/fc_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : fc_addr_gen
// Input index k and weight-row base for the current neuron, with k==0 / last flags.
// Rev    : 1.0
// ============================================================================
module fc_addr_gen
  import fc_pkg::*;
#(
  parameter int CNT_W   = FC_CNT_W,
  parameter int WADDR_W = FC_WADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_restart,
  input  logic               i_clear,
  input  logic               i_step,
  input  logic               i_advance,
  input  logic [CNT_W-1:0]   i_num_in,
  output logic [CNT_W-1:0]   o_node_addr,
  output logic [WADDR_W-1:0] o_wegt_addr,
  output logic               o_first,
  output logic               o_last
);

  logic [CNT_W-1:0]   k_q, k_d;
  logic [WADDR_W-1:0] wbase_q, wbase_d;

  always_comb begin
    k_d     = k_q;
    wbase_d = wbase_q;
    if (i_clear) begin
      k_d = '0;
    end else if (i_step) begin
      k_d = k_q + CNT_W'(1);
    end
    // Row base grows by num_in per neuron, so no multiplier is needed.
    if (i_restart) begin
      wbase_d = '0;
    end else if (i_advance) begin
      wbase_d = wbase_q + WADDR_W'(i_num_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      wbase_q <= '0;
    end else begin
      k_q     <= k_d;
      wbase_q <= wbase_d;
    end
  end

  assign o_node_addr = k_q;
  assign o_wegt_addr = wbase_q + WADDR_W'(k_q);
  assign o_first     = (k_q == '0);
  assign o_last      = (k_q == i_num_in - CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/fc_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fc_layer_ctrl
// Sequences one MAC core through a fully connected layer, one neuron at a time.
// Rev    : 1.0
// ============================================================================
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int DATA_W  = FC_DATA_W,
  parameter int CNT_W   = FC_CNT_W,
  parameter int WADDR_W = FC_WADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_in,
  input  logic [CNT_W-1:0] i_num_out,
  output logic             o_busy,
  output logic             o_done,
  fc_layer_ctrl_if.master  bus
);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   num_in_q, num_in_d;
  logic [CNT_W-1:0]   num_out_q, num_out_d;
  logic [CNT_W-1:0]   j_q, j_d;
  logic               core_valid_q, core_valid_d;
  logic [DATA_W-1:0]  core_bias_q, core_bias_d;

  logic               start_ok;
  logic               clear;
  logic               feed;
  logic               write;
  logic               xfer;
  logic               last_neuron;
  logic               first_beat;
  logic               last_beat;
  logic [CNT_W-1:0]   node_addr;
  logic [WADDR_W-1:0] wegt_addr;

  assign start_ok    = (state_q == ST_IDLE) && i_start;
  assign clear       = (state_q == ST_CLEAR);
  assign feed        = (state_q == ST_FEED);
  assign write       = (state_q == ST_WRITE);
  assign xfer        = write && bus.i_res_ready;
  assign last_neuron = (j_q == num_out_q - CNT_W'(1));

  fc_addr_gen #(
    .CNT_W   (CNT_W),
    .WADDR_W (WADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .i_restart   (start_ok),
    .i_clear     (clear),
    .i_step      (feed),
    .i_advance   (xfer),
    .i_num_in    (num_in_q),
    .o_node_addr (node_addr),
    .o_wegt_addr (wegt_addr),
    .o_first     (first_beat),
    .o_last      (last_beat)
  );

  always_comb begin
    state_d   = state_q;
    num_in_d  = num_in_q;
    num_out_d = num_out_q;
    j_d       = j_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          num_in_d  = i_num_in;
          num_out_d = i_num_out;
          j_d       = '0;
          state_d   = (i_num_in == '0 || i_num_out == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED: begin
        if (last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        if (bus.i_res_ready) begin
          j_d     = j_q + CNT_W'(1);
          state_d = last_neuron ? ST_DONE : ST_CLEAR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bias data return in the first FEED cycle, aligned with the k==0 read,
  // so both reach the core together one cycle later.
  always_comb begin
    core_valid_d = feed;
    core_bias_d  = (feed && first_beat) ? bus.i_bias_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      num_in_q     <= '0;
      num_out_q    <= '0;
      j_q          <= '0;
      core_valid_q <= 1'b0;
      core_bias_q  <= '0;
    end else begin
      state_q      <= state_d;
      num_in_q     <= num_in_d;
      num_out_q    <= num_out_d;
      j_q          <= j_d;
      core_valid_q <= core_valid_d;
      core_bias_q  <= core_bias_d;
    end
  end

  assign o_busy           = (state_q != ST_IDLE);
  assign o_done           = (state_q == ST_DONE);

  assign bus.o_mem_en     = feed;
  assign bus.o_node_addr  = feed ? node_addr : '0;
  assign bus.o_wegt_addr  = feed ? wegt_addr : '0;
  assign bus.o_bias_en    = clear;
  assign bus.o_bias_addr  = clear ? j_q : '0;
  assign bus.o_core_run   = clear;
  assign bus.o_core_valid = core_valid_q;
  assign bus.o_core_bias  = core_bias_q;
  // Core is idle in WRITE (no run, no valid), so its result is stable here.
  assign bus.o_res_valid  = write;
  assign bus.o_res_addr   = write ? j_q : '0;
  assign bus.o_res_data   = write ? bus.i_core_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_layer_ctrl
// Self-checking bench: memories and MAC core models around fc_layer_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_fc_layer_ctrl;

  localparam int CW = 8;

  typedef struct {
    int addr;
    int data;
  } res_t;

  typedef struct {
    int     n_in;
    int     n_out;
    int     mode;
    int     stall;
    int     inject;
    int     exp_done;
    int     has_r0;
    int     exp_r0;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_num_in = '0;
  logic [CW-1:0] i_num_out = '0;
  logic          o_busy;
  logic          o_done;
  logic          ready = 1'b1;

  fc_layer_ctrl_if bus ();

  fc_layer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_num_in  (i_num_in),
    .i_num_out (i_num_out),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  node_mem [256];
  logic [7:0]  wegt_mem [65536];
  logic [7:0]  bias_mem [256];
  logic [7:0]  node_rd = '0;
  logic [7:0]  wegt_rd = '0;
  logic [7:0]  bias_rd = '0;
  logic [31:0] acc = '0;
  int          prod;

  assign bus.i_bias_data   = bias_rd;
  assign bus.i_core_result = acc;
  assign bus.i_res_ready   = ready;

  // Environment: 1-cycle memories and a MAC core adding bias on every valid beat.
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      node_rd <= node_mem[bus.o_node_addr];
      wegt_rd <= wegt_mem[bus.o_wegt_addr];
    end
    if (bus.o_bias_en) bias_rd <= bias_mem[bus.o_bias_addr];
    prod = int'($signed(node_rd)) * int'($signed(wegt_rd));
    if (bus.o_core_run) acc <= '0;
    else if (bus.o_core_valid) acc <= acc + prod + int'($signed(bus.o_core_bias));
  end

  int   n_checks = 0;
  int   n_pass = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   stall_left = 0;
  int   mem_beats = 0;
  int   bias_beats = 0;
  int   viol = 0;
  int   last_wa = 0;
  bit   hold_prev = 1'b0;
  logic [40:0] prev_v = '0;
  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic any_out();
    return |{o_busy, o_done, bus.o_mem_en, bus.o_node_addr, bus.o_wegt_addr,
             bus.o_bias_en, bus.o_bias_addr, bus.o_core_run, bus.o_core_valid,
             bus.o_core_bias, bus.o_res_valid, bus.o_res_addr, bus.o_res_data};
  endfunction

  // Monitor and result-port driver, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_mem_en) begin
        mem_beats++;
        last_wa = int'(bus.o_wegt_addr);
      end
      if (bus.o_core_valid && bus.o_core_bias != '0) bias_beats++;
      if (!bus.o_core_valid && bus.o_core_bias != '0) viol++;
      if (bus.o_res_valid && (bus.o_mem_en || bus.o_core_valid || bus.o_core_run)) viol++;
      if (hold_prev)
        check("hold_stable", longint'({bus.o_res_valid, bus.o_res_addr, bus.o_res_data}),
              longint'(prev_v));
      if (bus.o_res_valid && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
        hold_prev = 1'b1;
        prev_v = {bus.o_res_valid, bus.o_res_addr, bus.o_res_data};
      end else begin
        ready = 1'b1;
        hold_prev = 1'b0;
        if (bus.o_res_valid)
          got_q.push_back('{int'(bus.o_res_addr), int'($signed(bus.o_res_data))});
      end
    end
  end

  task automatic fill(input int mode, input int n_in, input int n_out);
    if (mode == 0) begin
      node_mem[0] = 8'd1;  node_mem[1] = 8'd2;  node_mem[2] = 8'd3;
      wegt_mem[0] = 8'd1;  wegt_mem[1] = 8'd1;  wegt_mem[2] = 8'd1;
      wegt_mem[3] = 8'hFF; wegt_mem[4] = 8'd2;  wegt_mem[5] = 8'hFD;
      bias_mem[0] = 8'd10; bias_mem[1] = 8'hFB;
    end else if (mode == 1) begin
      for (int k = 0; k < n_in; k++) begin
        node_mem[k] = 8'h80;
        wegt_mem[k] = 8'h80;
      end
      bias_mem[0] = 8'd127;
    end else if (mode == 2) begin
      for (int k = 0; k < n_in; k++) node_mem[k] = 8'($urandom);
      for (int a = 0; a < n_in * n_out; a++) wegt_mem[a] = 8'($urandom);
      for (int j = 0; j < n_out; j++) bias_mem[j] = 8'($urandom);
    end
  endtask

  // Reference: each neuron is bias + dot(node, weight row j), row j at j*n_in.
  task automatic build_expected(input int n_in, input int n_out, output int bias_nz);
    exp_q.delete();
    bias_nz = 0;
    if (n_in == 0 || n_out == 0) return;
    for (int j = 0; j < n_out; j++) begin
      int s;
      s = int'($signed(bias_mem[j]));
      if (bias_mem[j] != 8'd0) bias_nz++;
      for (int k = 0; k < n_in; k++)
        s += int'($signed(node_mem[k])) * int'($signed(wegt_mem[(j * n_in + k) % 65536]));
      exp_q.push_back('{j, s});
    end
  endtask

  task automatic run_layer(input vec_t v);
    int cyc;
    int done_at;
    int busy1;
    int bias_nz;
    build_expected(v.n_in, v.n_out, bias_nz);
    got_q.delete();
    stall_left = v.stall;
    mem_beats = 0;
    bias_beats = 0;
    viol = 0;
    last_wa = -1;
    @(negedge clk);
    i_start = 1'b1;
    i_num_in = CW'(v.n_in);
    i_num_out = CW'(v.n_out);
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc = 0;
    done_at = -1;
    busy1 = 0;
    while (done_at < 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = int'(o_busy);
      if (o_done) done_at = cyc;
      if (v.inject != 0 && cyc == 4) begin
        i_start = 1'b1;
        i_num_in = 8'd7;
        i_num_out = 8'd9;
      end else if (v.inject != 0 && cyc == 5) begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    check("done_latency", done_at, v.exp_done);
    check("busy_after_start", busy1, 1);
    check("result_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("result_addr", got_q[i].addr, exp_q[i].addr);
      check("result_data", got_q[i].data, exp_q[i].data);
    end
    if (v.has_r0 != 0 && got_q.size() > 0) check("first_result", got_q[0].data, v.exp_r0);
    check("bias_beats", bias_beats, bias_nz);
    check("mem_beats", mem_beats, (v.n_in == 0 || v.n_out == 0) ? 0 : v.n_in * v.n_out);
    check("last_wegt_addr", last_wa,
          (v.n_in == 0 || v.n_out == 0) ? -1 : (v.n_out * v.n_in - 1) % 65536);
    check("exclusive_outputs", viol, 0);
    @(negedge clk);
    check("done_pulse_single", int'({o_done, o_busy}), 0);
  endtask

  initial begin
    int dc;
    vecs[0] = '{3, 2, 0, 0, 0, 13, 1, 16};
    vecs[1] = '{3, 2, 0, 4, 0, 17, 1, 16};
    vecs[2] = '{0, 5, 3, 0, 0, 1, 0, 0};
    vecs[3] = '{255, 1, 1, 0, 0, 259, 1, 4178047};
    vecs[4] = '{3, 2, 0, 0, 1, 13, 1, 16};
    for (int i = 5; i < 10; i++) begin
      vecs[i].n_in     = int'($urandom_range(1, 20));
      vecs[i].n_out    = int'($urandom_range(1, 6));
      vecs[i].mode     = 2;
      vecs[i].stall    = int'($urandom_range(0, 3));
      vecs[i].inject   = 0;
      vecs[i].exp_done = vecs[i].n_out * (vecs[i].n_in + 3) + 1 + vecs[i].stall;
      vecs[i].has_r0   = 0;
      vecs[i].exp_r0   = 0;
    end

    repeat (3) @(negedge clk);
    check("reset_outputs_zero", any_out(), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      fill(vecs[i].mode, vecs[i].n_in, vecs[i].n_out);
      run_layer(vecs[i]);
    end

    // Reset during FEED of neuron 1 aborts the layer.
    fill(0, 3, 2);
    got_q.delete();
    stall_left = 0;
    @(negedge clk);
    i_start = 1'b1;
    i_num_in = 8'd3;
    i_num_out = 8'd2;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_in_feed", int'({bus.o_mem_en, bus.o_node_addr}), 9'h101);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs_zero", any_out(), 0);
    check("rst_results_before", got_q.size(), 1);
    reset = 1'b0;
    dc = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) dc++;
    end
    check("rst_no_done", dc, 0);
    check("rst_no_more_results", got_q.size(), 1);
    check("rst_idle", int'(o_busy), 0);
    run_layer(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
